// File: rtl/dlx_pkg.sv
// Shared DLX fetch types: decoder Pc_cmd/Pc_val encodings, fetch FSM states
// and the execute-stage redirect request bundle.
package dlx_pkg;

  localparam logic [1:0] PC_CMD_SEQ = 2'b00;
  localparam logic [1:0] PC_CMD_BR  = 2'b10;
  localparam logic [1:0] PC_CMD_JR  = 2'b11;

  localparam logic [1:0] PC_VAL_I16 = 2'b00;
  localparam logic [1:0] PC_VAL_I26 = 2'b01;
  localparam logic [1:0] PC_VAL_REG = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} fetch_state_t;

  // Execute-stage qualifiers; only iv[25:0] ever feeds an offset.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  pc_cmd;
    logic [1:0]  pc_val;
    logic [25:0] iv;
    logic [31:0] rs1_val;
    logic        branch_taken;
  } ex_req_t;

endpackage

// File: rtl/dlx_pc_target.sv
// Combinational redirect decision and target for the fetch stage.
// Target arithmetic wraps at 32 bits; the result is always word aligned.
module dlx_pc_target
  import dlx_pkg::*;
(
  input  ex_req_t     ex,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] seq_pc;
  logic [31:0] off16;
  logic [31:0] off26;
  logic [31:0] raw;

  assign seq_pc = ex.pc + 32'd4;
  assign off16  = {{16{ex.iv[15]}}, ex.iv[15:0]};
  assign off26  = {{6{ex.iv[25]}}, ex.iv[25:0]};

  // Redirect decision and raw target by Pc_cmd / Pc_val.
  always_comb begin
    redirect = 1'b0;
    raw      = seq_pc + off16;
    if (ex.valid) begin
      if (ex.pc_cmd == PC_CMD_JR)
        redirect = 1'b1;
      else if (ex.pc_cmd == PC_CMD_BR && (ex.pc_val == PC_VAL_I26 || ex.branch_taken))
        redirect = 1'b1;
    end
    case (ex.pc_val)
      PC_VAL_REG: raw = ex.rs1_val;
      PC_VAL_I26: raw = seq_pc + off26;
      default:    raw = seq_pc + off16;
    endcase
  end

  assign target = {raw[31:2], 2'b00};

endmodule

// File: rtl/dlx_fetch.sv
// DLX instruction-fetch stage: single-outstanding imem req/ack, valid/ready
// hand-off to the decoder, execute-driven redirects with highest priority.
// Optional: DLX_FETCH_STALL_CNT_EN adds a saturating perf_stall_cnt output.
module dlx_fetch
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        i_req,
  output logic [31:0] i_addr,
  input  logic        i_ack,
  input  logic [31:0] i_rdata,
  output logic        f_valid,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc,
  input  logic        d_ready,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [1:0]  ex_pc_cmd,
  input  logic [1:0]  ex_pc_val,
  input  logic [31:0] ex_iv,
  input  logic [31:0] ex_rs1_val,
  input  logic        ex_branch_taken
`ifdef DLX_FETCH_STALL_CNT_EN
  , output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  flush_addr_q, flush_addr_d;
  logic         f_valid_d;
  logic [31:0]  f_instr_d, f_pc_d;

  ex_req_t      ex;
  logic         redirect;
  logic [31:0]  target;

  // Upper iv bits never contribute to an offset, so they are not carried.
  assign ex = '{valid:        ex_valid,
                pc:           ex_pc,
                pc_cmd:       ex_pc_cmd,
                pc_val:       ex_pc_val,
                iv:           ex_iv[25:0],
                rs1_val:      ex_rs1_val,
                branch_taken: ex_branch_taken};

  dlx_pc_target u_pc_target (
    .ex       (ex),
    .redirect (redirect),
    .target   (target)
  );

  // The ex_iv[31:26] bits are intentionally dropped; fold them into a
  // dead reduction so the intent is explicit.
  logic iv_hi_unused;
  assign iv_hi_unused = ^ex_iv[31:26];

  // While flushing, the old address stays on the bus until its ack returns.
  assign i_req  = (state_q == REQ) || (state_q == FLUSH);
  assign i_addr = (state_q == FLUSH) ? flush_addr_q : pc_q;

  // Next-state and datapath updates; redirect overrides every other event.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_addr_d = flush_addr_q;
    f_valid_d    = f_valid;
    f_instr_d    = f_instr;
    f_pc_d       = f_pc;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = target;
      end
      REQ: begin
        if (redirect) begin
          pc_d = target;
          if (i_ack) begin
            state_d = REQ;
          end else begin
            state_d      = FLUSH;
            flush_addr_d = pc_q;
          end
        end else if (i_ack) begin
          f_instr_d = i_rdata;
          f_pc_d    = pc_q;
          f_valid_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d      = target;
          f_valid_d = 1'b0;
          state_d   = REQ;
        end else if (f_valid && d_ready) begin
          pc_d      = pc_q + 32'd4;
          f_valid_d = 1'b0;
          state_d   = REQ;
        end
      end
      FLUSH: begin
        if (redirect) pc_d = target;
        if (i_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) f_valid_d = 1'b0;
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      flush_addr_q <= RESET_PC;
      f_valid      <= 1'b0;
      f_instr      <= '0;
      f_pc         <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_addr_q <= flush_addr_d;
      f_valid      <= f_valid_d;
      f_instr      <= f_instr_d;
      f_pc         <= f_pc_d;
    end
  end

`ifdef DLX_FETCH_STALL_CNT_EN
  logic stall;
  assign stall = i_req || (f_valid && !d_ready);

  // Saturating count of cycles waiting on imem or on the decoder.
  always_ff @(posedge clk) begin
    if (!reset_n)
      perf_stall_cnt <= '0;
    else if (stall && perf_stall_cnt != 32'hFFFF_FFFF)
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dlx_fetch.sv
// Directed self-checking bench for dlx_fetch.
module tb_dlx_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack = 1'b0;
  logic [31:0] i_rdata = '0;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        d_ready = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [1:0]  ex_pc_cmd = '0;
  logic [1:0]  ex_pc_val = '0;
  logic [31:0] ex_iv = '0;
  logic [31:0] ex_rs1_val = '0;
  logic        ex_branch_taken = 1'b0;
`ifdef DLX_FETCH_STALL_CNT_EN
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlx_fetch #(.RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .i_ack           (i_ack),
    .i_rdata         (i_rdata),
    .f_valid         (f_valid),
    .f_instr         (f_instr),
    .f_pc            (f_pc),
    .d_ready         (d_ready),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_pc_cmd       (ex_pc_cmd),
    .ex_pc_val       (ex_pc_val),
    .ex_iv           (ex_iv),
    .ex_rs1_val      (ex_rs1_val),
    .ex_branch_taken (ex_branch_taken)
`ifdef DLX_FETCH_STALL_CNT_EN
    , .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex;
    ex_valid = 1'b0; ex_pc = '0; ex_pc_cmd = 2'b00; ex_pc_val = 2'b00;
    ex_iv = '0; ex_rs1_val = '0; ex_branch_taken = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; i_ack = 1'b0; clear_ex();
    tick(); tick();
    checks++; if (i_req !== 1'b0) begin errors++; $display("FAIL rst_i_req act=%b exp=0", i_req); end
    checks++; if (i_addr !== 32'h0) begin errors++; $display("FAIL rst_i_addr act=%h exp=0", i_addr); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rst_f_valid act=%b exp=0", f_valid); end
    checks++; if (f_instr !== 32'h0) begin errors++; $display("FAIL rst_f_instr act=%h exp=0", f_instr); end
    checks++; if (f_pc !== 32'h0) begin errors++; $display("FAIL rst_f_pc act=%h exp=0", f_pc); end
`ifdef DLX_FETCH_STALL_CNT_EN
    checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_perf act=%h exp=0", perf_stall_cnt); end
`endif
  endtask

  // Three sequential fetches, each acked two cycles after the request.
  task automatic test_seq_fetch;
    logic [31:0] exp;
    reset_n = 1'b1; d_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp = 32'(k) * 32'd4;
      checks++; if (i_req !== 1'b1 || i_addr !== exp) begin errors++; $display("FAIL seq_req k=%0d act=%b/%h exp=1/%h", k, i_req, i_addr, exp); end
      tick(); tick();
      checks++; if (i_req !== 1'b1 || i_addr !== exp) begin errors++; $display("FAIL seq_hold_req k=%0d act=%b/%h exp=1/%h", k, i_req, i_addr, exp); end
      i_ack = 1'b1; i_rdata = 32'hA000_0000 + 32'(k);
      tick();
      i_ack = 1'b0;
      checks++; if (f_valid !== 1'b1 || f_pc !== exp || f_instr !== 32'hA000_0000 + 32'(k) || i_req !== 1'b0) begin
        errors++; $display("FAIL seq_out k=%0d act=%b/%h/%h/%b exp=1/%h/%h/0", k, f_valid, f_pc, f_instr, i_req, exp, 32'hA000_0000 + 32'(k)); end
      tick();
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL seq_handoff k=%0d act=%b exp=0", k, f_valid); end
    end
  endtask

  // Decoder back-pressure for 5 cycles while holding the fetched word at 0xC.
  task automatic test_stall;
    d_ready = 1'b0; i_ack = 1'b1; i_rdata = 32'hBEEF_0001;
    tick();
    i_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (f_valid !== 1'b1 || f_instr !== 32'hBEEF_0001 || f_pc !== 32'hC || i_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold c=%0d act=%b/%h/%h/%b exp=1/beef0001/0000000c/0", c, f_valid, f_instr, f_pc, i_req); end
      tick();
    end
    d_ready = 1'b1;
    tick();
    checks++; if (f_valid !== 1'b0 || i_req !== 1'b1 || i_addr !== 32'h10) begin
      errors++; $display("FAIL stall_release act=%b/%b/%h exp=0/1/00000010", f_valid, i_req, i_addr); end
  endtask

  // Redirect while request outstanding: FLUSH keeps old address, drops data.
  task automatic test_flush;
    ex_valid = 1'b1; ex_pc_cmd = 2'b10; ex_pc_val = 2'b01; ex_pc = 32'h100; ex_iv = 32'h03FF_FFF8;
    tick();
    clear_ex();
    checks++; if (i_req !== 1'b1 || i_addr !== 32'h10 || f_valid !== 1'b0) begin
      errors++; $display("FAIL flush_hold act=%b/%h/%b exp=1/00000010/0", i_req, i_addr, f_valid); end
    tick();
    i_ack = 1'b1; i_rdata = 32'hDEAD_DEAD;
    tick();
    i_ack = 1'b0;
    checks++; if (f_valid !== 1'b0 || i_req !== 1'b1 || i_addr !== 32'hFC) begin
      errors++; $display("FAIL flush_target act=%b/%b/%h exp=0/1/000000fc", f_valid, i_req, i_addr); end
    i_ack = 1'b1; i_rdata = 32'h1111_1111;
    tick();
    i_ack = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'hFC || f_instr !== 32'h1111_1111) begin
      errors++; $display("FAIL flush_fetch act=%b/%h/%h exp=1/000000fc/11111111", f_valid, f_pc, f_instr); end
    tick();
    checks++; if (i_addr !== 32'h100) begin errors++; $display("FAIL flush_next act=%h exp=00000100", i_addr); end
  endtask

  // Redirect and ack in the same cycle: data dropped, new target requested.
  task automatic test_ack_redirect;
    i_ack = 1'b1; i_rdata = 32'h0BAD_0BAD;
    ex_valid = 1'b1; ex_pc_cmd = 2'b11; ex_pc_val = 2'b11; ex_rs1_val = 32'h2003;
    tick();
    i_ack = 1'b0; clear_ex();
    checks++; if (f_valid !== 1'b0 || i_req !== 1'b1 || i_addr !== 32'h2000) begin
      errors++; $display("FAIL ackredir act=%b/%b/%h exp=0/1/00002000", f_valid, i_req, i_addr); end
    i_ack = 1'b1; i_rdata = 32'h2222_2222;
    tick();
    i_ack = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h2000) begin
      errors++; $display("FAIL ackredir_fetch act=%b/%h exp=1/00002000", f_valid, f_pc); end
    tick();
  endtask

  // Untaken BEQZ lets the ack through; taken one in HOLD beats d_ready.
  task automatic test_branch_cond;
    ex_valid = 1'b1; ex_pc_cmd = 2'b10; ex_pc_val = 2'b00; ex_pc = 32'h40; ex_iv = 32'h10;
    ex_branch_taken = 1'b0;
    i_ack = 1'b1; i_rdata = 32'h3333_3333;
    tick();
    i_ack = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h2004 || f_instr !== 32'h3333_3333) begin
      errors++; $display("FAIL br_untaken act=%b/%h/%h exp=1/00002004/33333333", f_valid, f_pc, f_instr); end
    ex_branch_taken = 1'b1; d_ready = 1'b1;
    tick();
    clear_ex();
    checks++; if (f_valid !== 1'b0 || i_req !== 1'b1 || i_addr !== 32'h54) begin
      errors++; $display("FAIL br_taken act=%b/%b/%h exp=0/1/00000054", f_valid, i_req, i_addr); end
  endtask

  // Jump-register to the last word, then sequential wrap to 0.
  task automatic test_wrap;
    i_ack = 1'b1; i_rdata = 32'h0;
    ex_valid = 1'b1; ex_pc_cmd = 2'b11; ex_pc_val = 2'b11; ex_rs1_val = 32'hFFFF_FFFF;
    tick();
    i_ack = 1'b0; clear_ex();
    checks++; if (i_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target act=%h exp=fffffffc", i_addr); end
    i_ack = 1'b1; i_rdata = 32'h4444_4444;
    tick();
    i_ack = 1'b0;
    checks++; if (f_pc !== 32'hFFFF_FFFC || f_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_fetch act=%b/%h exp=1/fffffffc", f_valid, f_pc); end
    tick();
    checks++; if (i_addr !== 32'h0 || i_req !== 1'b1) begin errors++; $display("FAIL wrap_next act=%b/%h exp=1/00000000", i_req, i_addr); end
  endtask

  // Reset mid-request, late ack during IDLE is ignored.
  task automatic test_reset_mid;
    i_ack = 1'b1; i_rdata = 32'h0;
    ex_valid = 1'b1; ex_pc_cmd = 2'b11; ex_pc_val = 2'b11; ex_rs1_val = 32'h300;
    tick();
    i_ack = 1'b0; clear_ex();
    checks++; if (i_addr !== 32'h300 || i_req !== 1'b1) begin errors++; $display("FAIL rmid_pre act=%b/%h exp=1/00000300", i_req, i_addr); end
    reset_n = 1'b0;
    tick();
    checks++; if (i_req !== 1'b0 || i_addr !== 32'h0 || f_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_rst act=%b/%h/%b exp=0/00000000/0", i_req, i_addr, f_valid); end
    reset_n = 1'b1; i_ack = 1'b1; i_rdata = 32'h5555_5555;
    tick();
    i_ack = 1'b0;
    checks++; if (f_valid !== 1'b0 || i_req !== 1'b1 || i_addr !== 32'h0) begin
      errors++; $display("FAIL rmid_late_ack act=%b/%b/%h exp=0/1/00000000", f_valid, i_req, i_addr); end
    i_ack = 1'b1; i_rdata = 32'h6666_6666;
    tick();
    i_ack = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h0 || f_instr !== 32'h6666_6666) begin
      errors++; $display("FAIL rmid_fetch act=%b/%h/%h exp=1/00000000/66666666", f_valid, f_pc, f_instr); end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall();
    test_flush();
    test_ack_redirect();
    test_branch_cond();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
